// File: rtl/if_fetch_queue_pkg.sv
// Shared widths, reset PC and bus layouts for the decoupled fetch stage.
// Bus structs mirror the packed {..} concatenations used by the neighbouring stages.
package if_fetch_queue_pkg;

  localparam int WB_TO_IF_CSR_DATA_WIDTH = 66;
  localparam int BR_BUS_WIDTH            = 33;
  localparam int ID_BUS_WIDTH            = 65;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h1C00_0000;

  typedef struct packed {
    logic        adef;
    logic [31:0] inst;
    logic [31:0] pc;
  } id_bus_t;

  typedef struct packed {
    logic        ertn_flush;
    logic        ex_flush;
    logic [31:0] ex_entry;
    logic [31:0] era;
  } csr_redir_t;

  typedef struct packed {
    logic        taken;
    logic [31:0] target;
  } br_bus_t;

endpackage

// File: rtl/if_entry_fifo.sv
// In-order fetch queue: entries allocated at tail, filled in order at fill ptr, popped at head.
// Zero-latency head view; clear wins over every other operation in the same cycle.
module if_entry_fifo
  import if_fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_clear,
  input  logic                    i_alloc,
  input  logic                    i_alloc_adef,
  input  logic [31:0]             i_alloc_pc,
  input  logic                    i_fill,
  input  logic [31:0]             i_fill_inst,
  input  logic                    i_pop,
  output logic [$clog2(DEPTH):0]  o_count,
  output logic                    o_head_filled,
  output id_bus_t                 o_head
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0]    r_head;
  logic [PW-1:0]    r_fill;
  logic [PW-1:0]    r_tail;
  logic [PW:0]      r_count;
  logic [DEPTH-1:0] r_filled;
  id_bus_t          r_ent [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_head   <= '0;
      r_fill   <= '0;
      r_tail   <= '0;
      r_count  <= '0;
      r_filled <= '0;
      for (int i = 0; i < DEPTH; i++) r_ent[i] <= '0;
    end else if (i_clear) begin
      r_head   <= '0;
      r_fill   <= '0;
      r_tail   <= '0;
      r_count  <= '0;
      r_filled <= '0;
    end else begin
      if (i_pop) begin
        r_filled[r_head] <= 1'b0;
        r_head           <= r_head + PW'(1);
      end
      if (i_fill) begin
        r_ent[r_fill].inst <= i_fill_inst;
        r_filled[r_fill]   <= 1'b1;
        r_fill             <= r_fill + PW'(1);
      end
      // ADEF entries are born filled; alloc is last so it wins a full-queue pop on the same slot
      if (i_alloc) begin
        r_ent[r_tail]    <= '{adef: i_alloc_adef, inst: 32'h0, pc: i_alloc_pc};
        r_filled[r_tail] <= i_alloc_adef;
        r_tail           <= r_tail + PW'(1);
      end
      r_count <= r_count + (PW+1)'(i_alloc) - (PW+1)'(i_pop);
    end
  end

  assign o_count       = r_count;
  assign o_head_filled = r_filled[r_head];
  assign o_head        = r_ent[r_head];

endmodule

// File: rtl/if_fetch_queue.sv
// Decoupled fetch: PC generation, up to MAX_OUT in-flight SRAM requests, in-order queue to ID.
// Redirect->req 1 cycle, data_ok->id_valid 1 cycle; issue stalls when the queue is full.
module if_fetch_queue
  import if_fetch_queue_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter int          MAX_OUT  = DEPTH,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                               clk,
  input  logic                               reset,
  output logic                               inst_sram_req,
  output logic                               inst_sram_wr,
  output logic [1:0]                         inst_sram_size,
  output logic [3:0]                         inst_sram_wstrb,
  output logic [31:0]                        inst_sram_addr,
  output logic [31:0]                        inst_sram_wdata,
  input  logic                               inst_sram_addr_ok,
  input  logic                               inst_sram_data_ok,
  input  logic [31:0]                        inst_sram_rdata,
  input  logic [BR_BUS_WIDTH-1:0]            br_signal,
  input  logic [WB_TO_IF_CSR_DATA_WIDTH-1:0] wb_to_if_csr_data,
  input  logic                               id_allowin,
  output logic                               id_valid,
  output logic [ID_BUS_WIDTH-1:0]            id_bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  csr_redir_t    w_csr;
  br_bus_t       w_br;
  logic          w_flush;
  logic [31:0]   w_target;
  logic [31:0]   r_pc_req;
  logic [CW-1:0] r_out;
  logic [CW-1:0] r_discard;
  logic          r_adef_hold;
  logic [CW-1:0] w_count;
  logic          w_can_alloc;
  logic          w_aligned;
  logic          w_adef_alloc;
  logic          w_issue;
  logic          w_drop;
  logic          w_fill;
  logic          w_pop;
  logic          w_head_filled;
  id_bus_t       w_head;

  assign w_csr   = wb_to_if_csr_data;
  assign w_br    = br_signal;
  assign w_flush = w_csr.ertn_flush | w_csr.ex_flush | w_br.taken;

  always_comb begin
    w_target = w_br.target;
    if (w_csr.ertn_flush)    w_target = w_csr.era;
    else if (w_csr.ex_flush) w_target = w_csr.ex_entry;
  end

  // The queue count already includes entries still waiting on their response
  assign w_can_alloc  = !reset && !w_flush && !r_adef_hold &&
                        (w_count < CW'(DEPTH)) && (r_out < CW'(MAX_OUT));
  assign w_aligned    = (r_pc_req[1:0] == 2'b00);
  assign inst_sram_req = w_can_alloc && w_aligned;
  assign w_adef_alloc = w_can_alloc && !w_aligned;
  assign w_issue      = inst_sram_req && inst_sram_addr_ok;
  assign w_drop       = inst_sram_data_ok && (r_discard != '0);
  assign w_fill       = inst_sram_data_ok && (r_discard == '0) && !w_flush;

  assign id_valid = w_head_filled && !w_flush && !reset;
  assign id_bus   = w_head;
  assign w_pop    = id_valid && id_allowin;

  assign inst_sram_wr    = 1'b0;
  assign inst_sram_size  = 2'b10;
  assign inst_sram_wstrb = 4'h0;
  assign inst_sram_wdata = 32'h0;
  assign inst_sram_addr  = r_pc_req;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc_req    <= RESET_PC;
      r_out       <= '0;
      r_discard   <= '0;
      r_adef_hold <= 1'b0;
    end else if (w_flush) begin
      // Everything still in flight becomes stale; its responses are swallowed by count
      r_pc_req    <= w_target;
      r_out       <= '0;
      r_discard   <= r_discard + r_out + CW'(w_issue) - CW'(inst_sram_data_ok);
      r_adef_hold <= 1'b0;
    end else begin
      if (w_issue) r_pc_req <= r_pc_req + 32'd4;
      r_out     <= r_out + CW'(w_issue) - CW'(w_fill);
      r_discard <= r_discard - CW'(w_drop);
      if (w_adef_alloc) r_adef_hold <= 1'b1;
    end
  end

  if_entry_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk           (clk),
    .reset         (reset),
    .i_clear       (w_flush),
    .i_alloc       (w_issue || w_adef_alloc),
    .i_alloc_adef  (w_adef_alloc),
    .i_alloc_pc    (r_pc_req),
    .i_fill        (w_fill),
    .i_fill_inst   (inst_sram_rdata),
    .i_pop         (w_pop),
    .o_count       (w_count),
    .o_head_filled (w_head_filled),
    .o_head        (w_head)
  );

endmodule
